r_clk_module_srst: RTL and testbench
====================================

// Module: r_clk_module_srst
// PURPOSE
//  Read-domain half of the asynchronous FIFO. It owns the read pointer, the memory read address and the empty flags.
//  It synchronizes the write-domain Gray pointer into r_clk and derives a registered fill-level estimate.
//  It sits between the dual-port FIFO memory (read port) and the read-side consumer.
//  Its r_ptr output feeds the write-domain half's full detection.
// PARAMETERS
//  ADDRESS_SIZE      4  memory address width; depth = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits
//  ALMOST_EMPTY_TH   2  r_almost_empty asserts when level <= this value; range 0..2**ADDRESS_SIZE
// PORTS
//  r_clk           in   1               read clock; single clock domain
//  r_rst           in   1               reset, synchronous, active-high
//  r_en            in   1               read request from consumer
//  w_ptr           in   ADDRESS_SIZE+1  write pointer, Gray, write-domain (asynchronous to r_clk)
//  r_ptr           out  ADDRESS_SIZE+1  read pointer, Gray, registered; to write domain
//  r_addr          out  ADDRESS_SIZE    memory read address, binary, registered
//  r_empty         out  1               FIFO empty, registered
//  r_almost_empty  out  1               level <= ALMOST_EMPTY_TH, registered
//  r_level         out  ADDRESS_SIZE+1  entries available (pessimistic), registered, 0..2**ADDRESS_SIZE
// BEHAVIOUR
//  - Reset: sampled only on posedge r_clk. While r_rst=1, registers load on each edge:
//      r_ptr=0, r_addr=0, internal binary ptr r_bin=0, both sync stages=0;
//      r_empty=1, r_almost_empty=1, r_level=0. r_en is ignored in a reset cycle.
//    Reset mid-operation: everything returns to these values at the next edge; no partial update.
//  - Accept: rd_ok = r_en & !r_empty. A read with r_empty=1 is ignored; pointers and flags hold.
//  - Next state (combinational):
//      r_bnext = r_bin + rd_ok, modulo 2**(ADDRESS_SIZE+1)
//      r_gnext = r_bnext ^ (r_bnext >> 1)
//  - Registers every edge: r_bin<=r_bnext; r_ptr<=r_gnext; r_addr<=r_bnext[ADDRESS_SIZE-1:0].
//    r_addr is the address of the word the consumer sees as head; memory read data is the consumer's concern.
//  - Synchronizer: two flops on r_clk, rq1<=w_ptr, rq2<=rq1; Gray guarantees at most one changing bit.
//  - Empty: r_empty <= (r_gnext == rq2). Asserts on the same edge that accepts the last available word; never over-reads.
//  - Level: wbin = gray_to_binary(rq2); lvl_next = (wbin - r_bnext) mod 2**(ADDRESS_SIZE+1); r_level <= lvl_next.
//  - Almost empty: r_almost_empty <= (lvl_next <= ALMOST_EMPTY_TH).
//  - Latency: a w_ptr change is reflected in r_empty/r_level 3 r_clk edges later (2 sync + 1 flag).
//    Empty deassertion is pessimistic by design; assertion has zero-cycle latency from the accepted read.
//  - Wrap-around: r_bin rolls 2**(ADDRESS_SIZE+1)-1 -> 0. r_ptr changes exactly one bit per accepted read, including at the wrap.
//    r_addr rolls 2**ADDRESS_SIZE-1 -> 0. The MSB difference distinguishes full from empty on the write side.
//  - Simultaneous events: a write (w_ptr change) and a read in the same cycle are independent.
//    The read updates r_bnext now; the write appears 2 edges later via rq2. No lost or duplicated accounting.
//  - Invariant (assertion): lvl_next <= 2**ADDRESS_SIZE always; r_empty == (r_level == 0) after reset.
// STRUCTURE
//  - Shared FIFO package/include: gray_to_binary and binary_to_gray functions, pointer-width helper (ADDRESS_SIZE+1).
//    Used by both write and read halves.
//  - One sub-module: sync_2ff_srst (parameter SIZE; clk, rst active-high synchronous, in, out).
//    It is the two-flop synchronizer instantiated with SIZE=ADDRESS_SIZE+1 for w_ptr.
//  - Remaining logic (pointer, flags, level) is flat in this module.
// TESTING (ADDRESS_SIZE=4, ALMOST_EMPTY_TH=2)
//  1. r_rst=1 for 2 edges, r_en=1, w_ptr=5'h00 -> r_empty=1, r_almost_empty=1, r_ptr=0, r_addr=0, r_level=0; no pointer movement.
//  2. After reset, w_ptr 5'h00->5'h01 at edge 0 -> r_empty falls and r_level=1 after edge 3; r_almost_empty stays 1.
//  3. w_ptr=5'h18 (bin 16), wait 3 edges, r_en=1 for 20 cycles -> r_level=16 at start.
//     r_addr steps 0..15; r_empty=1 on the edge accepting the 16th read; r_ptr holds 5'h18 after; 4 extra reads ignored.
//  4. r_empty=1, r_en pulsed for 5 cycles -> r_ptr, r_addr, r_level unchanged.
//  5. Wrap: advance write and read through 40 words -> r_ptr Hamming distance 1 per read.
//     r_ptr goes 5'h10 -> 5'h00 at bin 31->0; r_addr goes 15->0; r_empty correct throughout.
//  6. Mid-stream: r_level=7, assert r_rst for 1 edge with r_en=1 -> all outputs at reset values next cycle.
//     After release with w_ptr stable at nonzero, r_empty falls 3 edges later.

Source files
------------

// File: rtl/r_clk_module_srst_pkg.sv
// rtl/r_clk_module_srst_pkg.sv - shared async FIFO pointer helpers (Gray/binary conversion, pointer width)
package r_clk_module_srst_pkg;

  // Pointers carry one extra bit beyond the address so full and empty can be told apart.
  function automatic int ptr_width(input int address_size);
    return address_size + 1;
  endfunction

  // Reflected binary code: adjacent values differ in exactly one bit.
  function automatic logic [31:0] binary_to_gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray_to_binary(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i + 1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/r_clk_module_srst_sync.sv
// rtl/r_clk_module_srst_sync.sv - two-flop synchronizer with synchronous active-high reset
module sync_2ff_srst #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in,
  output logic [SIZE-1:0] out
);

  logic [SIZE-1:0] q1;

  // First stage may go metastable; second stage gives it a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1  <= '0;
      out <= '0;
    end else begin
      q1  <= in;
      out <= q1;
    end
  end

endmodule

// File: rtl/r_clk_module_srst.sv
// rtl/r_clk_module_srst.sv - read-domain half of the async FIFO: read pointer, address, empty flags, level
module r_clk_module_srst
  import r_clk_module_srst_pkg::*;
#(
  parameter int ADDRESS_SIZE    = 4,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  r_en,
  input  logic [ADDRESS_SIZE:0] w_ptr,
  output logic [ADDRESS_SIZE:0] r_ptr,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic [ADDRESS_SIZE:0] r_level
);

  localparam int PW = ptr_width(ADDRESS_SIZE);
  localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDRESS_SIZE);
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_bnext;
  logic [PW-1:0] r_gnext;
  logic [PW-1:0] rq2;
  logic [PW-1:0] wbin;
  logic [PW-1:0] lvl_next;
  logic          rd_ok;

  sync_2ff_srst #(
    .SIZE (PW)
  ) u_w_ptr_sync (
    .clk (r_clk),
    .rst (r_rst),
    .in  (w_ptr),
    .out (rq2)
  );

  // Next read pointer and the pessimistic fill level seen from the read side.
  always_comb begin
    rd_ok    = r_en & ~r_empty;
    r_bnext  = r_bin + {{(PW - 1){1'b0}}, rd_ok};
    r_gnext  = PW'(binary_to_gray(32'(r_bnext)));
    wbin     = PW'(gray_to_binary(32'(rq2)));
    lvl_next = wbin - r_bnext;
  end

  // Pointer, address and flags all register together so the write side sees a coherent Gray pointer.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_addr         <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
    end else begin
      r_bin          <= r_bnext;
      r_ptr          <= r_gnext;
      r_addr         <= r_bnext[ADDRESS_SIZE-1:0];
      r_empty        <= (r_gnext == rq2);
      r_almost_empty <= (lvl_next <= AE_TH);
      r_level        <= lvl_next;
    end
  end

  // Level can never exceed depth, and the empty flag always agrees with a zero level.
  always_ff @(posedge r_clk) begin
    if (!r_rst) begin
      assert (lvl_next <= DEPTH);
      assert (r_empty == (r_level == '0));
    end
  end

endmodule

// File: tb/tb_r_clk_module_srst.sv
// tb/tb_r_clk_module_srst.sv - scoreboard bench for the read-domain half of the async FIFO
module tb_r_clk_module_srst;

  localparam int AS    = 4;
  localparam int TH    = 2;
  localparam int DEPTH = 16;
  localparam int MODV  = 32;

  logic          r_clk = 1'b0;
  logic          r_rst;
  logic          r_en;
  logic [AS:0]   w_ptr;
  logic [AS:0]   r_ptr;
  logic [AS-1:0] r_addr;
  logic          r_empty;
  logic          r_almost_empty;
  logic [AS:0]   r_level;

  r_clk_module_srst #(
    .ADDRESS_SIZE    (AS),
    .ALMOST_EMPTY_TH (TH)
  ) dut (
    .r_clk          (r_clk),
    .r_rst          (r_rst),
    .r_en           (r_en),
    .w_ptr          (w_ptr),
    .r_ptr          (r_ptr),
    .r_addr         (r_addr),
    .r_empty        (r_empty),
    .r_almost_empty (r_almost_empty),
    .r_level        (r_level)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    logic [AS:0]   ptr;
    logic [AS-1:0] addr;
    logic          empty;
    logic          ae;
    logic [AS:0]   level;
    bit            stepped;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counts of words written and read, and the write counts the read side has seen.
  int wcnt    = 0;
  int rd      = 0;
  int seen_new = 0;
  int seen_old = 0;
  int lvl     = 0;
  bit emp     = 1'b1;

  function automatic logic [AS:0] to_gray(input int b);
    logic [AS:0] x;
    x = AS'(0) + b[AS:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // A read side sees writes two edges late; it accepts a read only while it believes data is present.
  task automatic model_edge(input bit rst, input bit en);
    exp_t e;
    bit   acc;
    acc = 1'b0;
    if (rst) begin
      rd       = 0;
      seen_new = 0;
      seen_old = 0;
      lvl      = 0;
      emp      = 1'b1;
    end else begin
      acc      = en && !emp;
      rd       = (rd + (acc ? 1 : 0)) % MODV;
      lvl      = ((seen_old - rd) % MODV + MODV) % MODV;
      seen_old = seen_new;
      seen_new = wcnt;
      emp      = (lvl == 0);
    end
    e.ptr     = to_gray(rd);
    e.addr    = AS'(rd % DEPTH);
    e.empty   = emp;
    e.ae      = (lvl <= TH);
    e.level   = (AS + 1)'(lvl);
    e.stepped = acc;
    sb.push_back(e);
  endtask

  task automatic step(input bit rst, input bit en);
    r_rst = rst;
    r_en  = en;
    w_ptr = to_gray(wcnt);
    @(posedge r_clk);
    model_edge(rst, en);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a new registered state, compared against the oldest prediction.
  logic [AS:0] prev_ptr = '0;
  always @(negedge r_clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("r_ptr", int'(r_ptr), int'(e.ptr));
      check("r_addr", int'(r_addr), int'(e.addr));
      check("r_empty", int'(r_empty), int'(e.empty));
      check("r_almost_empty", int'(r_almost_empty), int'(e.ae));
      check("r_level", int'(r_level), int'(e.level));
      if (e.stepped) check("r_ptr_one_bit_change", $countones(r_ptr ^ prev_ptr), 1);
      prev_ptr = r_ptr;
    end
  end

  initial begin
    int waits;
    r_rst = 1'b1;
    r_en  = 1'b1;
    w_ptr = '0;

    // Reset with reads requested: nothing may move.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Single word becomes visible three edges later; almost-empty stays set.
    wcnt = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    // Full FIFO, drained with extra reads past empty.
    wcnt = 16;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // Reads while empty are ignored.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end

    // Random concurrent traffic, long enough to wrap the pointer several times.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && ((wcnt - rd + MODV) % MODV) < DEPTH) wcnt = (wcnt + 1) % MODV;
      step(1'b0, 1'($urandom_range(0, 1)));
    end

    // Drain, then build a level of seven and reset mid-stream with a read pending.
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      wcnt = (wcnt + 1) % MODV;
      step(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("level_before_reset", lvl, 7);
    wcnt = 5;
    step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

    waits = 0;
    while (sb.size() > 0 && waits < 20) begin
      @(posedge r_clk);
      waits++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
